// File: rtl/one_hot_encoder_pkg.sv
// Shared widths for the one-hot encoder/decoder pair.
// No logic; constants only, so both codec halves agree on code widths.
// Changing OH_N requires OH_W to track ceil(log2(OH_N)).
package one_hot_encoder_pkg;

    localparam int OH_N = 32;
    localparam int OH_W = $clog2(OH_N);

endpackage

// File: rtl/onehot_prienc.sv
// LSB-priority index search over a one-hot code, with zero/multi-hot detection.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module onehot_prienc
    import one_hot_encoder_pkg::*;
#(
    parameter int N = OH_N,
    parameter int W = OH_W
) (
    input  logic [N-1:0] bin,
    output logic [W-1:0] idx,
    output logic         zero,
    output logic         multi
);

    // Descending scan so the lowest set bit is the last assignment to win.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bin[i]) begin
                idx = W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign zero  = ~|bin;
    assign multi = |(bin & (bin - N'(1)));

endmodule

// File: rtl/one_hot_encoder.sv
// One-hot to binary encoder with LSB priority, error flags and a saturating error counter.
// Latency: one cycle from input transfer to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds in place.
module one_hot_encoder
    import one_hot_encoder_pkg::*;
#(
    parameter int N = OH_N,
    parameter int W = OH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] Bin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] Bout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err_zero,
    output logic         err_multi,
    input  logic         err_clr,
    output logic [7:0]   err_count
);

    logic [W-1:0] enc_idx;
    logic         enc_zero;
    logic         enc_multi;
    logic         in_xfer;

    onehot_prienc #(
        .N (N),
        .W (W)
    ) u_prienc (
        .bin   (Bin),
        .idx   (enc_idx),
        .zero  (enc_zero),
        .multi (enc_multi)
    );

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            Bout      <= '0;
            err_zero  <= 1'b0;
            err_multi <= 1'b0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            Bout      <= enc_idx;
            err_zero  <= enc_zero;
            err_multi <= enc_multi;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_count <= 8'd0;
        end else if (in_xfer && (enc_zero || enc_multi) && (err_count != 8'hff)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_one_hot_encoder.sv
// Directed self-checking bench for one_hot_encoder; the decoder half of the
// round trip is modelled here as a plain shift.
module tb_one_hot_encoder;

    logic        clk;
    logic        rst;
    logic [31:0] Bin;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  Bout;
    logic        out_valid;
    logic        out_ready;
    logic        err_zero;
    logic        err_multi;
    logic        err_clr;
    logic [7:0]  err_count;

    int compared;
    int mismatched;

    one_hot_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .Bin       (Bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Bout      (Bout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_zero  (err_zero),
        .err_multi (err_multi),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; Bin = 32'h0000_0001; in_valid = 1'b1; out_ready = 1'b1; err_clr = 1'b0;
        step();
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        compared++;
        if (Bout !== 5'd0) begin mismatched++; $display("FAIL reset_bout got %0d want 0", Bout); end
        compared++;
        if ({err_zero, err_multi} !== 2'b00) begin mismatched++; $display("FAIL reset_err_flags got %b want 00", {err_zero, err_multi}); end
        compared++;
        if (err_count !== 8'd0) begin mismatched++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_sweep();
        logic [31:0] one;
        one = 32'h0000_0001;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            Bin = one << i; in_valid = 1'b1;
            step();
            compared++;
            if (out_valid !== 1'b1 || Bout !== 5'(i) || err_zero !== 1'b0 || err_multi !== 1'b0) begin
                mismatched++;
                $display("FAIL sweep_%0d got v=%0b bout=%0d z=%0b m=%0b want v=1 bout=%0d z=0 m=0",
                         i, out_valid, Bout, err_zero, err_multi, i);
            end
        end
        in_valid = 1'b0; Bin = 32'hdead_beef;
        step();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL sweep_drain got %0b want 0", out_valid); end
        compared++;
        if (err_count !== 8'd0) begin mismatched++; $display("FAIL sweep_err_count got %0d want 0", err_count); end
    endtask

    task automatic test_errors();
        out_ready = 1'b1;
        Bin = 32'h0000_0000; in_valid = 1'b1;
        step();
        compared++;
        if (Bout !== 5'd0 || err_zero !== 1'b1 || err_multi !== 1'b0) begin
            mismatched++; $display("FAIL err_zero_code got bout=%0d z=%0b m=%0b want 0 1 0", Bout, err_zero, err_multi);
        end
        Bin = 32'h0000_0028;
        step();
        compared++;
        if (Bout !== 5'd3 || err_zero !== 1'b0 || err_multi !== 1'b1) begin
            mismatched++; $display("FAIL err_multi_code got bout=%0d z=%0b m=%0b want 3 0 1", Bout, err_zero, err_multi);
        end
        in_valid = 1'b0; Bin = 32'h0000_0000;
        step();
        compared++;
        if (err_count !== 8'd2) begin mismatched++; $display("FAIL err_count_two got %0d want 2", err_count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1; Bin = 32'h0000_0400; in_valid = 1'b1;
        step();
        out_ready = 1'b0; Bin = 32'h8000_0000;
        for (int c = 0; c < 4; c++) begin
            #1;
            compared++;
            if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready_%0d got %0b want 0", c, in_ready); end
            step();
            compared++;
            if (out_valid !== 1'b1 || Bout !== 5'd10) begin
                mismatched++; $display("FAIL bp_hold_%0d got v=%0b bout=%0d want v=1 bout=10", c, out_valid, Bout);
            end
        end
        out_ready = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_in_ready got %0b want 1", in_ready); end
        step();
        compared++;
        if (out_valid !== 1'b1 || Bout !== 5'd31) begin
            mismatched++; $display("FAIL bp_next got v=%0b bout=%0d want v=1 bout=31", out_valid, Bout);
        end
        in_valid = 1'b0;
        step();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1; Bin = 32'h0000_0000; in_valid = 1'b1;
        repeat (300) step();
        compared++;
        if (err_count !== 8'd255) begin mismatched++; $display("FAIL sat_count got %0d want 255", err_count); end
        err_clr = 1'b1;
        step();
        compared++;
        if (err_count !== 8'd0) begin mismatched++; $display("FAIL clr_priority got %0d want 0", err_count); end
        err_clr = 1'b0; in_valid = 1'b0;
        step();
        compared++;
        if (err_count !== 8'd0) begin mismatched++; $display("FAIL clr_idle got %0d want 0", err_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; Bin = 32'h0000_0000; in_valid = 1'b1;
        step();
        Bin = 32'h0000_0080;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        step();
        compared++;
        if (out_valid !== 1'b1 || Bout !== 5'd7 || err_count !== 8'd1) begin
            mismatched++; $display("FAIL rstmid_setup got v=%0b bout=%0d cnt=%0d want 1 7 1", out_valid, Bout, err_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || Bout !== 5'd0 || err_count !== 8'd0) begin
            mismatched++; $display("FAIL rstmid_cleared got v=%0b bout=%0d cnt=%0d want 0 0 0", out_valid, Bout, err_count);
        end
        out_ready = 1'b1; Bin = 32'h0000_0002; in_valid = 1'b1;
        step();
        compared++;
        if (out_valid !== 1'b1 || Bout !== 5'd1) begin
            mismatched++; $display("FAIL rstmid_first got v=%0b bout=%0d want 1 1", out_valid, Bout);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] one;
        logic [4:0]  v;
        one = 32'h0000_0001;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            v = 5'($urandom_range(0, 31));
            Bin = one << v; in_valid = 1'b1;
            step();
            compared++;
            if (out_valid !== 1'b1 || Bout !== v || err_zero !== 1'b0 || err_multi !== 1'b0) begin
                mismatched++; $display("FAIL roundtrip_%0d got v=%0b bout=%0d want v=1 bout=%0d", k, out_valid, Bout, v);
            end
        end
        in_valid = 1'b0;
        step();
        compared++;
        if (err_count !== 8'd0) begin mismatched++; $display("FAIL roundtrip_err_count got %0d want 0", err_count); end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_sweep();
        test_errors();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/one_hot_encoder.md
ONE_HOT_ENCODER -- requirements
Module: one_hot_encoder

Interface
REQ-001 The block SHALL have parameter N, default 32: one-hot input width.
REQ-002 The block SHALL have parameter W, default 5: binary output width, equal to ceil(log2(N)).
REQ-003 The block SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port Bin, input, N: one-hot input code.
REQ-006 The block SHALL have port in_valid, input, 1: Bin is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1: block accepts Bin this cycle.
REQ-008 The block SHALL have port Bout, output, W: registered base-2 binary code.
REQ-009 The block SHALL have port out_valid, output, 1: Bout and error flags are valid.
REQ-010 The block SHALL have port out_ready, input, 1: downstream accepts Bout this cycle.
REQ-011 The block SHALL have port err_zero, output, 1: registered, set when the accepted Bin had no bit set.
REQ-012 The block SHALL have port err_multi, output, 1: registered, set when the accepted Bin had more than one bit set.
REQ-013 The block SHALL have port err_clr, input, 1: synchronous clear of err_count.
REQ-014 The block SHALL have port err_count, output, 8: saturating count of accepted erroneous codes.

Function
REQ-015 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-016 in_ready SHALL equal (!out_valid || out_ready), combinationally; there SHALL be no combinational path from in_valid to any output.
REQ-017 Latency SHALL be one cycle: an input transfer at edge k SHALL present Bout, err_zero and err_multi with out_valid=1 after edge k.
REQ-018 Bout SHALL be the index of the lowest-numbered set bit of Bin (LSB priority).
REQ-019 For zero-hot Bin, Bout SHALL be 0, err_zero SHALL be 1 and err_multi SHALL be 0.
REQ-020 For multi-hot Bin, Bout SHALL follow REQ-018 and err_multi SHALL be 1.
REQ-021 While out_valid=1 and out_ready=0, Bout, err_zero, err_multi and out_valid SHALL hold; no input SHALL be accepted.
REQ-022 Simultaneous output and input transfer in one cycle SHALL load the new result with out_valid kept at 1 (full throughput, one code per cycle).
REQ-023 An output transfer without an input transfer SHALL clear out_valid after the edge.
REQ-024 err_count SHALL increment by 1 on each input transfer with err_zero or err_multi conditions true, and SHALL saturate at 255.
REQ-025 err_clr=1 SHALL set err_count to 0 on the next edge and SHALL take priority over a simultaneous increment.
REQ-026 Bin contents while in_valid=0 SHALL have no effect on any state.

Reset
REQ-027 rst=1 at a rising edge SHALL set out_valid=0, Bout=0, err_zero=0, err_multi=0 and err_count=0, overriding all other inputs.
REQ-028 A result held mid-handshake SHALL be discarded by reset, and the block SHALL accept input on the first edge after rst deasserts.

Structure
REQ-029 The constants N=32 and W=5 SHALL reside in the team's shared package/include for the one-hot codec pair, so encoder and decoder agree on widths.
REQ-030 The combinational LSB-priority search plus zero/multi detection SHALL be one sub-module, onehot_prienc, instantiated once; the handshake register and counter SHALL stay in one_hot_encoder.

Verification
REQ-031 The bench SHALL cover the exhaustive sweep: Bin=1<<i for i=0..31, out_ready=1 -> Bout=i one cycle later, err_zero=err_multi=0, err_count stays 0.
REQ-032 The bench SHALL cover error codes: Bin=0 -> Bout=0, err_zero=1; Bin=32'h0000_0028 -> Bout=3, err_multi=1; err_count=2 afterwards.
REQ-033 The bench SHALL cover backpressure: accept Bin=32'h0000_0400, hold out_ready=0 for 4 cycles with in_valid=1 and Bin=32'h8000_0000 -> Bout holds 10, in_ready=0; release -> Bout=10 taken, then Bout=31.
REQ-034 The bench SHALL cover saturation and clear: 300 transfers of Bin=0 -> err_count=255; err_clr asserted with a simultaneous Bin=0 transfer -> err_count=0.
REQ-035 The bench SHALL cover reset mid-operation: rst pulsed while out_valid=1 and out_ready=0 with Bout=7 -> out_valid=0, err_count=0 next cycle; next Bin=32'h0000_0002 -> Bout=1.
REQ-036 The bench SHALL cover round-trip: random 5-bit values through the team's decoder then this encoder at full throughput -> output equals input, one result per cycle.
